reg_file: RTL and testbench

Parametrised multi-register storage block for the CRP16 datapath: a bank of `2**addr_bits` registers, each `width` bits wide, with one write port, two combinational read ports, write-to-read bypass and a per-register busy scoreboard. It replaces banks of individual single registers in the CPU core. The decode stage marks destination registers pending, and the writeback stage clears the pending state when it writes the result.

---
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 121 ++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: register bank with one write port, two combinational read ports, write bypass and busy scoreboard
module reg_file #(
  parameter int width = 16,
  parameter int addr_bits = 3,
  parameter bit zero_reg = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wren,
  input  logic [addr_bits-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [addr_bits-1:0] raddr_a,
  input  logic [addr_bits-1:0] raddr_b,
  output logic [width-1:0]     qa,
  output logic [width-1:0]     qb,
  input  logic                 busy_set,
  input  logic [addr_bits-1:0] busy_addr,
  output logic                 busy_a,
  output logic                 busy_b
);
  localparam int depth = 2 ** addr_bits;
  logic [width-1:0] regs [depth];
  logic [depth-1:0] busy;
  logic wr_ok, bs_ok, byp_a, byp_b;
  assign wr_ok = wren & ~(zero_reg && waddr == '0);
  assign bs_ok = busy_set & ~(zero_reg && busy_addr == '0);
  assign byp_a = wr_ok & ~reset & (waddr == raddr_a);
  assign byp_b = wr_ok & ~reset & (waddr == raddr_b);
  // storage and scoreboard update; a busy_set issued alongside a write to the same register wins
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < depth; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (bs_ok) busy[busy_addr] <= 1'b1;
    end
  // combinational read with write-through bypass; the suppressed zero register is never written so reads 0
  always_comb begin
    qa = byp_a ? wdata : regs[raddr_a];
    qb = byp_b ? wdata : regs[raddr_b];
    busy_a = busy[raddr_a] & ~(wren & ~reset & (waddr == raddr_a));
    busy_b = busy[raddr_b] & ~(wren & ~reset & (waddr == raddr_b));
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: three reg_file configurations driven in lockstep, checked against an array model via a scoreboard
module tb_reg_file;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1, wren = 1'b0, busy_set = 1'b0;
  logic [3:0] waddr = '0, raddr_a = '0, raddr_b = '0, busy_addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] qa0, qb0, qa1, qb1;
  logic [7:0] qa2, qb2;
  logic ba0, bb0, ba1, bb1, ba2, bb2;
  int errors = 0, checks = 0;

  reg_file #(.width(16), .addr_bits(3), .zero_reg(1'b0)) d0 (
    .clock(clock), .reset(reset), .wren(wren), .waddr(waddr[2:0]), .wdata(wdata),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .qa(qa0), .qb(qb0),
    .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .busy_a(ba0), .busy_b(bb0));
  reg_file #(.width(16), .addr_bits(3), .zero_reg(1'b1)) d1 (
    .clock(clock), .reset(reset), .wren(wren), .waddr(waddr[2:0]), .wdata(wdata),
    .raddr_a(raddr_a[2:0]), .raddr_b(raddr_b[2:0]), .qa(qa1), .qb(qb1),
    .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .busy_a(ba1), .busy_b(bb1));
  reg_file #(.width(8), .addr_bits(4), .zero_reg(1'b0)) d2 (
    .clock(clock), .reset(reset), .wren(wren), .waddr(waddr), .wdata(wdata[7:0]),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .qa(qa2), .qb(qb2),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(ba2), .busy_b(bb2));

  typedef struct packed {logic [15:0] qa, qb; logic ba, bb;} exp_t;
  typedef exp_t [2:0] trio_t;
  trio_t sb[$];
  trio_t e;
  logic [15:0] mreg [3][16];
  logic mbusy [3][16];
  logic [3:0] amask [3] = '{4'h7, 4'h7, 4'hf};
  logic [15:0] dmask [3] = '{16'hffff, 16'hffff, 16'h00ff};
  bit zr [3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] ra, input logic [3:0] rb, input logic bs, input logic [3:0] bad);
    trio_t t;
    logic [3:0] w_a, r_a, r_b, b_a;
    logic wr_ok;
    @(posedge clock);
    #1;
    reset = r; wren = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; busy_set = bs; busy_addr = bad;
    for (int k = 0; k < 3; k++) begin
      w_a = wa & amask[k]; r_a = ra & amask[k]; r_b = rb & amask[k]; b_a = bad & amask[k];
      wr_ok = w && !r && !(zr[k] && w_a == 0);
      t[k].qa = (r || (zr[k] && r_a == 0)) ? 16'h0 : (wr_ok && w_a == r_a) ? (wd & dmask[k]) : mreg[k][r_a];
      t[k].qb = (r || (zr[k] && r_b == 0)) ? 16'h0 : (wr_ok && w_a == r_b) ? (wd & dmask[k]) : mreg[k][r_b];
      t[k].ba = !r && mbusy[k][r_a] && !(w && w_a == r_a);
      t[k].bb = !r && mbusy[k][r_b] && !(w && w_a == r_b);
      if (r) begin
        for (int j = 0; j < 16; j++) begin
          mreg[k][j] = '0;
          mbusy[k][j] = 1'b0;
        end
      end else begin
        if (wr_ok) begin
          mreg[k][w_a] = wd & dmask[k];
          mbusy[k][w_a] = 1'b0;
        end
        if (bs && !(zr[k] && b_a == 0)) mbusy[k][b_a] = 1'b1;
      end
    end
    sb.push_back(t);
  endtask

  always @(negedge clock)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("d0.qa", qa0, e[0].qa); chk("d0.qb", qb0, e[0].qb);
      chk("d0.busy_a", 16'(ba0), 16'(e[0].ba)); chk("d0.busy_b", 16'(bb0), 16'(e[0].bb));
      chk("d1.qa", qa1, e[1].qa); chk("d1.qb", qb1, e[1].qb);
      chk("d1.busy_a", 16'(ba1), 16'(e[1].ba)); chk("d1.busy_b", 16'(bb1), 16'(e[1].bb));
      chk("d2.qa", {8'h0, qa2}, e[2].qa); chk("d2.qb", {8'h0, qb2}, e[2].qb);
      chk("d2.busy_a", 16'(ba2), 16'(e[2].ba)); chk("d2.busy_b", 16'(bb2), 16'(e[2].bb));
    end

  initial begin
    step(1, 0, 0, 16'h0, 0, 0, 0, 0);
    step(0, 1, 3, 16'h1234, 3, 5, 1, 5);
    step(0, 0, 0, 16'h0, 3, 5, 0, 0);
    step(1, 0, 0, 16'h0, 3, 5, 0, 0);
    step(0, 0, 0, 16'h0, 3, 5, 0, 0);
    step(0, 1, 2, 16'hbeef, 0, 0, 0, 0);
    step(0, 0, 0, 16'h0, 2, 2, 0, 0);
    step(0, 1, 7, 16'h0001, 2, 7, 0, 0);
    step(0, 0, 0, 16'h0, 7, 2, 0, 0);
    step(0, 1, 4, 16'h1111, 0, 0, 0, 0);
    step(0, 1, 4, 16'h2222, 4, 4, 0, 0);
    step(0, 0, 0, 16'h0, 4, 4, 0, 0);
    step(0, 0, 0, 16'h0, 6, 6, 1, 6);
    step(0, 0, 0, 16'h0, 6, 6, 0, 0);
    step(0, 1, 6, 16'haaaa, 6, 6, 0, 0);
    step(0, 0, 0, 16'h0, 6, 6, 0, 0);
    step(0, 1, 6, 16'h5555, 6, 6, 1, 6);
    step(0, 0, 0, 16'h0, 6, 6, 0, 0);
    step(0, 1, 0, 16'hffff, 0, 0, 1, 0);
    step(0, 0, 0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 16'(i * 17 + 16'h0a00), 4'(i), 4'(15 - i), 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 16'h0, 4'(i), 4'(15 - i), 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), 16'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom), 4'($urandom));
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
